// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and constants for the instruction fetch front end
package ifetch_pkg;
   localparam int INSTR_BYTES = 4;
   typedef enum logic {RUN, DRAIN} fetch_state_e;
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: power-of-two synchronous FIFO with flush, registered storage and no bypass
module fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;
   assign empty   = count == '0;
   assign full    = count == CW'(DEPTH);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];
   // pointer and occupancy tracking; flush empties the queue without touching storage
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(do_push);
         rd_ptr <= rd_ptr + AW'(do_pop);
         count  <= count + CW'(do_push) - CW'(do_pop);
      end
   end
   // storage write at the tail
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end
   // a push into a full queue without a matching pop would lose data
   always_ff @(posedge clk) begin
      if (!rst && !flush) assert (!(push && full && !do_pop));
   end
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC owner issuing credit-limited fetches and buffering in-order responses; IFETCH_PERF_EN adds perf counters
module instr_fetch
   import ifetch_pkg::*;
#(
   parameter int              XLEN       = 32,
   parameter logic [XLEN-1:0] RESET_PC   = '0,
   parameter int              FIFO_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [XLEN-1:0] instr_data,
`ifdef IFETCH_PERF_EN
   output logic [XLEN-1:0] instr_pc,
   output logic [31:0]     perf_fetched,
   output logic [31:0]     perf_stall,
   output logic [31:0]     perf_flush
`else
   output logic [XLEN-1:0] instr_pc
`endif
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   fetch_state_e      state;
   fetch_state_e      state_nx;
   logic [XLEN-1:0]   pc;
   logic [XLEN-1:0]   pc_nx;
   logic [XLEN-1:0]   tag_pc;
   logic [2*XLEN-1:0] head;
   logic [CW-1:0]     outstanding;
   logic [CW-1:0]     outstanding_nx;
   logic [CW-1:0]     drop;
   logic [CW-1:0]     drop_nx;
   logic [CW-1:0]     eff_out;
   logic [CW-1:0]     buf_count;
   logic [CW-1:0]     tag_count;
   logic              req_fire;
   logic              rsp_take;
   logic              pop;
   logic              buf_full;
   logic              buf_empty;
   logic              tag_full;
   logic              tag_empty;
   assign imem_req_valid = !rst && state == RUN && !redirect_valid && !tag_full &&
                           int'(outstanding) + int'(buf_count) < FIFO_DEPTH;
   assign imem_req_addr  = pc;
   assign req_fire       = imem_req_valid && imem_req_ready;
   assign rsp_take       = imem_rsp_valid && state == RUN && !redirect_valid;
   assign pop            = instr_valid && instr_ready && !redirect_valid;
   assign eff_out        = outstanding - CW'(imem_rsp_valid);
   assign instr_valid    = !buf_empty;
   assign instr_data     = instr_valid ? head[2*XLEN-1:XLEN] : '0;
   assign instr_pc       = instr_valid ? head[XLEN-1:0] : '0;
   // pc tags of accepted requests, consumed as their responses are kept
   fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(XLEN)) u_tag (
      .clk(clk), .rst(rst), .push(req_fire), .pop(rsp_take), .flush(redirect_valid),
      .din(pc), .dout(tag_pc), .full(tag_full), .empty(tag_empty), .count(tag_count)
   );
   // instruction buffer holding {instr, pc} pairs for the core
   fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(2*XLEN)) u_buf (
      .clk(clk), .rst(rst), .push(rsp_take), .pop(pop), .flush(redirect_valid),
      .din({imem_rsp_data, tag_pc}), .dout(head), .full(buf_full), .empty(buf_empty), .count(buf_count)
   );
   // next pc, credits and drain bookkeeping; a redirect overrides sequential fetch
   always_comb begin
      pc_nx          = req_fire ? pc + XLEN'(INSTR_BYTES) : pc;
      outstanding_nx = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
      drop_nx        = state == DRAIN ? drop - CW'(imem_rsp_valid) : drop;
      state_nx       = state == DRAIN && drop_nx == '0 ? RUN : state;
      if (redirect_valid) begin
         pc_nx = redirect_pc & ~XLEN'(3);
         if (state == RUN) begin
            drop_nx  = eff_out;
            state_nx = eff_out == '0 ? RUN : DRAIN;
         end
      end
   end
   // fetch state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= RUN;
         pc          <= RESET_PC;
         outstanding <= '0;
         drop        <= '0;
      end else begin
         state       <= state_nx;
         pc          <= pc_nx;
         outstanding <= outstanding_nx;
         drop        <= drop_nx;
      end
   end
   // kept responses always have a tag and a buffer slot; tags track credits while running
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(rsp_take && tag_empty));
         assert (!(rsp_take && buf_full && !pop));
         assert (state == DRAIN || tag_count == outstanding);
      end
   end
`ifdef IFETCH_PERF_EN
   // saturating event counters for delivered instructions, starved cycles and redirects
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_fetched <= '0;
         perf_stall   <= '0;
         perf_flush   <= '0;
      end else begin
         perf_fetched <= perf_fetched + 32'(pop && perf_fetched != '1);
         perf_stall   <= perf_stall + 32'(instr_ready && !instr_valid && perf_stall != '1);
         perf_flush   <= perf_flush + 32'(redirect_valid && perf_flush != '1);
      end
   end
`endif
endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction fetch front end that sits directly upstream of the `microprocessor` decode/execute path.
- Owns the program counter and issues word-aligned requests to instruction memory over a valid/ready request channel.
- Accepts in-order responses and buffers them in a small FIFO.
- Presents instruction and PC pairs to the core over a valid/ready handshake.
- Handles control-flow redirects by flushing the FIFO and discarding stale in-flight responses.

Parameters:
- XLEN, 32: address and instruction width.
- RESET_PC, 32'h0000_0000: PC loaded on reset. Must be 4-byte aligned.
- FIFO_DEPTH, 2: instruction buffer entries. Must be a power of two, ≥ 2. This is also the maximum number of outstanding requests.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_req_addr  out  XLEN  fetch address; bits [1:0] are always 0.
- imem_rsp_valid  in  1  response data valid. Responses are in order and arrive at least 1 cycle after acceptance.
- imem_rsp_data  in  XLEN  fetched instruction word.
- redirect_valid  in  1  branch/jump taken; single-cycle pulse.
- redirect_pc  in  XLEN  new fetch target. Bits [1:0] are ignored (forced to 0).
- instr_valid  out  1  instruction available to the core.
- instr_ready  in  1  core consumes the instruction this cycle.
- instr_data  out  XLEN  instruction word.
- instr_pc  out  XLEN  address of `instr_data`.

Behaviour:
- Reset (rst=1 at a clk edge) sets:
  - pc=RESET_PC, FIFO empty, outstanding=0, drop=0, state=RUN.
  - imem_req_valid=0, instr_valid=0, instr_data=0, instr_pc=0.
  - Reset mid-operation abandons all in-flight requests. Responses arriving after reset are ignored, which requires drop to be set to 0 and the memory to be reset alongside this block.
- Request issue (state RUN only):
  - imem_req_valid=1 when outstanding + fifo_count < FIFO_DEPTH and redirect_valid=0.
  - imem_req_addr=pc.
  - On req_valid&&req_ready: pc <= pc+4 (wraps modulo 2^XLEN), outstanding++.
- Response (not dropping):
  - Push {rsp_data, rsp_pc} into the FIFO and decrement outstanding.
  - rsp_pc comes from an internal in-order PC tag queue of depth FIFO_DEPTH.
  - The credit rule guarantees the FIFO never overflows. An overflow is an assertion failure in simulation.
- Output:
  - instr_valid = FIFO not empty; instr_data/instr_pc = FIFO head.
  - Pop on instr_valid&&instr_ready.
  - Push and pop in the same cycle are allowed; count is unchanged.
  - Latency: a request accepted at cycle N with its response at N+1 yields instr_valid at N+2 (registered FIFO, no bypass).
- FSM states: RUN, DRAIN.
  - RUN → RUN on redirect when the effective outstanding count is 0. Effective outstanding = outstanding minus any response arriving that same cycle.
  - RUN → DRAIN on redirect when effective outstanding > 0; drop <= effective outstanding.
  - In DRAIN:
    - No requests are issued.
    - Each rsp_valid decrements drop and outstanding, and its data is discarded.
    - When drop reaches 0, go to RUN on the same edge. Issue resumes the next cycle.
  - A redirect while in DRAIN updates pc only. drop is unchanged; the remaining stale responses are still discarded.
- Any redirect, in either state:
  - pc <= {redirect_pc[XLEN-1:2], 2'b00}.
  - FIFO flushed; instr_valid=0 the next cycle.
  - A pop in the same cycle is lost; the redirect wins.
  - A response arriving in the redirect cycle is discarded.
  - imem_req_valid is forced to 0 in the redirect cycle.
- Once imem_req_valid is asserted, it stays stable until ready, unless a redirect occurs.

Optional Feature:
- Macro: IFETCH_PERF_EN.
- When defined, adds output ports:
  - perf_fetched (32 bits): instructions popped to the core.
  - perf_stall (32 bits): cycles with instr_ready=1 and instr_valid=0.
  - perf_flush (32 bits): redirects.
- All counters reset to 0, saturate at 32'hFFFF_FFFF, and are updated synchronously.
- When not defined, these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Package `ifetch_pkg`:
  - typedef fetch_state_e {RUN, DRAIN}.
  - typedef fetch_entry_t struct {instr, pc}.
  - localparam INSTR_BYTES=4.
- Sub-module `fetch_fifo` (parameterised depth/width; push, pop, flush, full, empty, count) instantiated twice: once for the instruction buffer and once for the PC tag queue.

Test Plan:
- Reset, 1-cycle memory, instr_ready=1 → request addresses 0x0, 0x4, 0x8…; first instr_valid on cycle 3 after reset release with instr_pc=0x0; back-to-back thereafter.
- instr_ready=0 for 10 cycles → at most 2 requests issued; FIFO full; imem_req_valid=0; on release, instr_pc sequence 0x0, 0x4 with no loss.
- imem_req_ready=0 for 5 cycles → req_valid held with addr stable at 0x0; no pc advance.
- 3-cycle memory latency with 2 outstanding, redirect to 0x100 → DRAIN; 2 responses discarded; next request addr 0x100; first delivered instr_pc=0x100.
- Redirect to 0x203 coincident with a response and a pop → the response is dropped, fetch restarts at 0x200, and no stale instruction is delivered.
- pc=0xFFFF_FFFC fetch → next address wraps to 0x0. With IFETCH_PERF_EN, perf_fetched and perf_flush match the scoreboard counts.
